// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART sizing constants for receiver, rx FIFO and tx FIFO
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receive FIFO push/pop/status bundle
// Purpose: groups the receiver push side, register-side pop side and status
// flags of the receive FIFO.
// Modports:
//   master - drives i_wr_valid/i_wr_data/i_rd/i_clr_overrun/i_flush, observes o_*
//   slave  - the FIFO: observes i_*, drives o_rd_data/o_empty/o_full/o_level/o_irq/o_overrun
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = UART_FIFO_DEPTH
) ();

  localparam int LW = $clog2(DEPTH) + 1;

  logic                  i_wr_valid;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  i_rd;
  logic                  i_clr_overrun;
  logic                  i_flush;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic                  o_empty;
  logic                  o_full;
  logic [LW-1:0]         o_level;
  logic                  o_irq;
  logic                  o_overrun;

  modport master (
    output i_wr_valid, i_wr_data, i_rd, i_clr_overrun, i_flush,
    input  o_rd_data, o_empty, o_full, o_level, o_irq, o_overrun
  );

  modport slave (
    input  i_wr_valid, i_wr_data, i_rd, i_clr_overrun, i_flush,
    output o_rd_data, o_empty, o_full, o_level, o_irq, o_overrun
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - DEPTH x DATA_WIDTH register array, sync write, async read
// Ports:
//   i_clk   - write clock
//   i_we    - write enable
//   i_waddr - write address
//   i_wdata - write data
//   i_raddr - read address
//   o_rdata - combinational read of mem[i_raddr]
// Storage has no reset; contents are only meaningful where the owner has written.
module uart_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive FIFO with level, irq and overrun
// Ports:
//   i_clk, i_reset_n - clock, asynchronous active-low reset
//   bus (slave)      - push (i_wr_valid/i_wr_data), pop (i_rd), i_flush,
//                      i_clr_overrun; head o_rd_data, o_empty, o_full,
//                      o_level, o_irq (level >= THRESH), sticky o_overrun
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = UART_FIFO_DEPTH,
  parameter int THRESH     = 8
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  uart_rx_fifo_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          overrun;

  logic empty;
  logic full;
  logic pop_ok;
  logic push_ok;
  logic overrun_set;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

  // A full FIFO can still take a byte when the head leaves on the same edge.
  assign pop_ok      = bus.i_rd && !empty;
  assign push_ok     = bus.i_wr_valid && (!full || pop_ok);
  // A flushed byte is discarded by the flush, not lost to a full FIFO.
  assign overrun_set = bus.i_wr_valid && full && !pop_ok && !bus.i_flush;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (bus.i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push_ok && !pop_ok) begin
        level <= level + LW'(1);
      end else if (pop_ok && !push_ok) begin
        level <= level - LW'(1);
      end
    end
  end

  // Set takes priority over clear so a drop in the clearing cycle is not lost.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      overrun <= 1'b0;
    end else if (overrun_set) begin
      overrun <= 1'b1;
    end else if (bus.i_clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (push_ok && !bus.i_flush),
    .i_waddr (wr_ptr),
    .i_wdata (bus.i_wr_data),
    .i_raddr (rd_ptr),
    .o_rdata (bus.o_rd_data)
  );

  assign bus.o_empty   = empty;
  assign bus.o_full    = full;
  assign bus.o_level   = level;
  assign bus.o_irq     = (level >= LW'(THRESH));
  assign bus.o_overrun = overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int DW     = 8;
  localparam int DEPTH  = 16;
  localparam int THRESH = 8;

  logic clk;
  logic rst_n;

  uart_rx_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .THRESH     (THRESH)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus a sticky flag.
  logic [DW-1:0] q[$];
  bit            m_ovr;
  bit            m_can_pop;
  int            m_size;

  initial begin
    q.delete();
    m_ovr = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_ovr = 0;
      end else begin
        m_size    = q.size();
        m_can_pop = bus.i_rd && (m_size > 0);
        if (bus.i_clr_overrun) m_ovr = 0;
        if (!bus.i_flush && bus.i_wr_valid && m_size == DEPTH && !m_can_pop) m_ovr = 1;
        if (bus.i_flush) begin
          q.delete();
        end else begin
          if (m_can_pop) void'(q.pop_front());
          if (bus.i_wr_valid && (m_size < DEPTH || m_can_pop)) q.push_back(bus.i_wr_data);
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("m_level",   32'(bus.o_level),   32'(q.size()));
      check("m_empty",   32'(bus.o_empty),   32'(q.size() == 0));
      check("m_full",    32'(bus.o_full),    32'(q.size() == DEPTH));
      check("m_irq",     32'(bus.o_irq),     32'(q.size() >= THRESH));
      check("m_overrun", 32'(bus.o_overrun), 32'(m_ovr));
      if (q.size() > 0) check("m_rd_data", 32'(bus.o_rd_data), 32'(q[0]));
    end
  end

  task automatic idle();
    bus.i_wr_valid    = 1'b0;
    bus.i_wr_data     = '0;
    bus.i_rd          = 1'b0;
    bus.i_clr_overrun = 1'b0;
    bus.i_flush       = 1'b0;
  endtask

  // Present one cycle of inputs, return 1 time unit after the edge that took them.
  task automatic cyc(input bit wr, input logic [7:0] d, input bit rd, input bit clr, input bit fl);
    bus.i_wr_valid    = wr;
    bus.i_wr_data     = d;
    bus.i_rd          = rd;
    bus.i_clr_overrun = clr;
    bus.i_flush       = fl;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    check("rst_empty",   32'(bus.o_empty),   32'd1);
    check("rst_full",    32'(bus.o_full),    32'd0);
    check("rst_level",   32'(bus.o_level),   32'd0);
    check("rst_irq",     32'(bus.o_irq),     32'd0);
    check("rst_overrun", 32'(bus.o_overrun), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: three bytes in, three out
    push(8'h41); push(8'h42); push(8'h43);
    check("t1_level", 32'(bus.o_level), 32'd3);
    check("t1_head",  32'(bus.o_rd_data), 32'h41);
    pop();
    check("t1_head2", 32'(bus.o_rd_data), 32'h42);
    pop();
    check("t1_head3", 32'(bus.o_rd_data), 32'h43);
    pop();
    check("t1_empty", 32'(bus.o_empty), 32'd1);
    check("t1_level0", 32'(bus.o_level), 32'd0);
    pop();
    check("t1_rd_empty_ignored", 32'(bus.o_level), 32'd0);

    // 2: fill, irq from 8th push, overrun on 17th, drain in order
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      check("t2_irq", 32'(bus.o_irq), 32'(i >= 7));
    end
    check("t2_full", 32'(bus.o_full), 32'd1);
    push(8'hFF);
    check("t2_overrun", 32'(bus.o_overrun), 32'd1);
    check("t2_level16", 32'(bus.o_level), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("t2_drain", 32'(bus.o_rd_data), 32'(i));
      pop();
    end
    check("t2_empty", 32'(bus.o_empty), 32'd1);

    // 3: full with simultaneous push and pop
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("t3_clr", 32'(bus.o_overrun), 32'd0);
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    cyc(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    check("t3_level", 32'(bus.o_level), 32'd16);
    check("t3_no_overrun", 32'(bus.o_overrun), 32'd0);
    for (int i = 1; i < 16; i++) begin
      check("t3_drain", 32'(bus.o_rd_data), 32'(8'h10 + i));
      pop();
    end
    check("t3_last", 32'(bus.o_rd_data), 32'hAA);
    pop();
    check("t3_empty", 32'(bus.o_empty), 32'd1);

    // 4: empty with simultaneous push and pop
    cyc(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    check("t4_level", 32'(bus.o_level), 32'd1);
    check("t4_head", 32'(bus.o_rd_data), 32'h5A);
    pop();

    // 5: flush beats push, overrun untouched; clear; set beats clear
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    push(8'hEE);
    for (int i = 0; i < 11; i++) pop();
    check("t5_level5", 32'(bus.o_level), 32'd5);
    check("t5_ovr_set", 32'(bus.o_overrun), 32'd1);
    cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    check("t5_flush_level", 32'(bus.o_level), 32'd0);
    check("t5_flush_empty", 32'(bus.o_empty), 32'd1);
    check("t5_flush_ovr", 32'(bus.o_overrun), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("t5_clr", 32'(bus.o_overrun), 32'd0);
    for (int i = 0; i < 16; i++) push(8'(8'h30 + i));
    cyc(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    check("t5_set_wins", 32'(bus.o_overrun), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t5_flushed", 32'(bus.o_level), 32'd0);

    // 6: asynchronous reset mid-operation
    for (int i = 0; i < 10; i++) push(8'(8'h50 + i));
    check("t6_level10", 32'(bus.o_level), 32'd10);
    check("t6_irq_pre", 32'(bus.o_irq), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_level", 32'(bus.o_level), 32'd0);
    check("t6_empty", 32'(bus.o_empty), 32'd1);
    check("t6_irq", 32'(bus.o_irq), 32'd0);
    check("t6_overrun", 32'(bus.o_overrun), 32'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(8'hC3);
    check("t6_after_head", 32'(bus.o_rd_data), 32'hC3);
    check("t6_after_level", 32'(bus.o_level), 32'd1);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer sitting directly downstream of the UART receiver. It captures each single-cycle byte-ready pulse plus data byte into a circular FIFO, and presents a first-word-fall-through read port to the CPU-side peripheral register logic. It also reports fill level, a threshold interrupt and a sticky overrun flag, so the core can tolerate multi-byte bursts without polling every byte time.

Parameters:
DATA_WIDTH, 8, width of each stored byte; matches the receiver data width.
DEPTH, 16, number of entries; must be a power of 2, minimum 2.
THRESH, 8, level at or above which o_irq asserts; range 1..DEPTH.

Ports:
i_clk  input  1  system clock
i_reset_n  input  1  asynchronous active-low reset
i_wr_valid  input  1  single-cycle byte-ready pulse from the receiver
i_wr_data  input  DATA_WIDTH  received byte; valid when i_wr_valid=1
i_rd  input  1  pop request from the register interface; one entry per asserted cycle
o_rd_data  output  DATA_WIDTH  head entry (FWFT); valid only while o_empty=0
o_empty  output  1  FIFO holds 0 entries
o_full  output  1  FIFO holds DEPTH entries
o_level  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH
o_irq  output  1  level-sensitive: o_level >= THRESH
o_overrun  output  1  sticky: a byte was dropped because the FIFO was full
i_clr_overrun  input  1  clears o_overrun
i_flush  input  1  discards all entries

Behaviour:
- Reset (asynchronous, i_reset_n=0): write and read pointers are 0, level is 0, o_overrun=0. Outputs are o_empty=1, o_full=0, o_level=0, o_irq=0. o_rd_data is don't-care; storage is not cleared.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Level is a separate registered counter, not derived from pointer difference.
- o_empty, o_full, o_irq and o_rd_data are decoded combinationally from registered state. o_rd_data = mem[rd_ptr].
- Push is accepted when i_wr_valid=1 and the FIFO is not full, or when it is full and a pop is accepted in the same cycle. An accepted push writes mem[wr_ptr] and advances wr_ptr on the same edge.
- Pop is accepted when i_rd=1 and o_empty=0. rd_ptr advances on the edge, and the new head appears on o_rd_data the following cycle. i_rd while empty is ignored with no side effects.
- Push and pop accepted in the same cycle: level unchanged, both pointers advance.
- Push and pop in the same cycle while empty: only the push is accepted; level becomes 1.
- Push and pop in the same cycle while full: both are accepted; level stays DEPTH; no overrun.
- Overrun: i_wr_valid=1 while full with no accepted pop → byte dropped, storage untouched, o_overrun=1 on the next edge.
- i_clr_overrun=1 clears o_overrun on the next edge. If a new overrun occurs in the same cycle, set wins and o_overrun stays 1.
- i_flush=1 has priority over push and pop in the same cycle: pointers go to 0, level goes to 0, and the incoming byte is discarded. o_overrun is unaffected by flush.
- Latency: write to visibility is 1 cycle (byte pushed at edge N appears on o_rd_data and o_empty=0 after edge N). Pop to next head is 1 cycle.
- Level arithmetic: +1 on push only, -1 on pop only. It never exceeds DEPTH and never underflows, guaranteed by the acceptance rules.
- Reset asserted mid-operation: the FIFO returns immediately to the reset state; any in-flight push is lost.

Decomposition:
- Shared package uart_pkg holds UART_DATA_WIDTH=8 and UART_FIFO_DEPTH=16, so the receiver, this block and the future transmit FIFO share one definition.
- One sub-module is natural: uart_fifo_mem. It is a DEPTH x DATA_WIDTH register array with a synchronous write port and an asynchronous read port, and is reused later by the transmit-side FIFO.
- Pointer, level and flag control stay in uart_rx_fifo.

Test Plan:
1. Reset, then push 0x41, 0x42, 0x43 as single-cycle pulses → o_level=3, o_rd_data=0x41. Three i_rd pulses → o_rd_data reads 0x42, then 0x43, then o_empty=1, o_level=0.
2. Push 16 bytes 0x00..0x0F → o_full=1, o_irq=1 from the 8th push onward. A 17th push of 0xFF → o_overrun=1, o_level=16. Drain all 16 → values 0x00..0x0F in order; 0xFF is never seen.
3. FIFO full, i_wr_valid with 0xAA and i_rd in the same cycle → o_level stays 16, o_overrun stays 0, and 0xAA is read last after draining.
4. FIFO empty, i_wr_valid with 0x5A and i_rd in the same cycle → o_level=1, o_rd_data=0x5A.
5. Five bytes queued with o_overrun=1; assert i_flush with i_wr_valid in the same cycle → o_level=0, o_empty=1, o_overrun still 1. Then i_clr_overrun → o_overrun=0. Clear and a new overrun in the same cycle → o_overrun stays 1.
6. Ten bytes queued; pulse i_reset_n low between clock edges → o_level=0, o_empty=1, o_irq=0, o_overrun=0 immediately, without waiting for a clock edge.
